// File: rtl/buck_ctrl_pkg.sv
// Shared types and limits for the multiphase buck gate-drive controller.
package buck_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HS    = 3'd1,
        ST_DT_HL = 3'd2,
        ST_LS    = 3'd3,
        ST_DT_LH = 3'd4
    } phase_state_t;

    // Shortest carrier period the master counter can wrap on.
    localparam int MIN_PERIOD = 2;
    // Shortest dead time; a programmed value of 0 still yields one gap cycle.
    localparam int MIN_DT     = 1;

endpackage

// File: rtl/pwm_phase_fsm.sv
// One phase of the gate driver: duty latch, hysteretic current comparator,
// dead-time counter and the hs/ls sequencing FSM.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | both gates off
//   ST_HS    | high-side on
//   ST_DT_HL | gap after high-side turned off, before low-side may turn on
//   ST_LS    | low-side on (synchronous rectification)
//   ST_DT_LH | gap before high-side (or before first low-side from idle)
module pwm_phase_fsm
    import buck_ctrl_pkg::*;
#(
    parameter int CNT_W = 12,
    parameter int DT_W  = 6,
    parameter int I_W   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [CNT_W-1:0]      i_cnt_k,
    input  logic [CNT_W-1:0]      i_duty,
    input  logic [DT_W-1:0]       i_dt,
    input  logic                  i_de_mode,
    input  logic signed [I_W-1:0] i_ind,
    input  logic signed [I_W-1:0] i_th_hi,
    input  logic signed [I_W-1:0] i_th_lo,
    output logic                  o_hs,
    output logic                  o_ls,
    output logic                  o_ls_en
);

    phase_state_t     r_state;
    phase_state_t     w_next;
    logic [CNT_W-1:0] r_duty_lat;
    logic [DT_W-1:0]  r_dt_cnt;
    logic [DT_W-1:0]  w_dt_last;
    logic             r_ls_en;
    logic             r_hs;
    logic             r_ls;
    logic             w_dem;
    logic             w_ls_ok;
    logic             w_dt_done;

    assign w_dem     = i_en & (i_cnt_k < r_duty_lat);
    assign w_ls_ok   = i_en & (~i_de_mode | r_ls_en);
    // Last dead-time count; >= lets a shortened dt end the gap right away.
    assign w_dt_last = (i_dt < DT_W'(MIN_DT)) ? DT_W'(MIN_DT - 1) : i_dt - DT_W'(MIN_DT);
    assign w_dt_done = (r_dt_cnt >= w_dt_last);

    // Duty is captured at this phase's own carrier start; comparator holds between thresholds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_duty_lat <= '0;
            r_ls_en    <= 1'b0;
        end else begin
            if (i_cnt_k == '0)
                r_duty_lat <= i_duty;
            if (i_ind > i_th_hi)
                r_ls_en <= 1'b1;
            else if (i_ind < i_th_lo)
                r_ls_en <= 1'b0;
        end
    end

    // Next-state logic: every hs/ls swap is routed through a dead-time state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_dem)
                    w_next = ST_HS;
                else if (w_ls_ok)
                    w_next = ST_DT_LH;
            end
            ST_HS: begin
                if (!w_dem)
                    w_next = ST_DT_HL;
            end
            ST_DT_HL: begin
                if (w_dem)
                    w_next = ST_HS;
                else if (w_dt_done)
                    w_next = w_ls_ok ? ST_LS : ST_IDLE;
            end
            ST_LS: begin
                if (w_dem || !w_ls_ok)
                    w_next = ST_DT_LH;
            end
            ST_DT_LH: begin
                if (w_dt_done) begin
                    if (w_dem)
                        w_next = ST_HS;
                    else if (w_ls_ok)
                        w_next = ST_LS;
                    else
                        w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, dead-time counter cleared on every state entry, registered gate decodes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_dt_cnt <= '0;
            r_hs     <= 1'b0;
            r_ls     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_dt_cnt <= (w_next != r_state) ? '0 : r_dt_cnt + DT_W'(1);
            r_hs     <= (w_next == ST_HS);
            r_ls     <= (w_next == ST_LS);
        end
    end

    assign o_hs    = r_hs;
    assign o_ls    = r_ls;
    assign o_ls_en = r_ls_en;

endmodule

// File: rtl/multiphase_pwm_dte.sv
// N-phase interleaved PWM with dead time and per-phase diode emulation.
// Owns the master carrier counter, the period latch and the phase offsets.
module multiphase_pwm_dte
    import buck_ctrl_pkg::*;
#(
    parameter int N_PHASES = 2,
    parameter int CNT_W    = 12,
    parameter int DT_W     = 6,
    parameter int I_W      = 16
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst,
    input  logic                    en,
    input  logic [CNT_W-1:0]        period,
    input  logic [CNT_W-1:0]        duty,
    input  logic [DT_W-1:0]         dt,
    input  logic                    de_mode,
    input  logic [N_PHASES*I_W-1:0] i_ind,
    input  logic signed [I_W-1:0]   th_hi,
    input  logic signed [I_W-1:0]   th_lo,
    output logic [N_PHASES-1:0]     hs,
    output logic [N_PHASES-1:0]     ls,
    output logic [N_PHASES-1:0]     ls_en,
    output logic                    sync
);

    localparam int LOG2N = $clog2(N_PHASES);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_lat;
    logic             r_sync;
    logic             w_wrap;
    logic [CNT_W-1:0] w_per_next;

    assign w_wrap     = (r_cnt == r_per_lat - CNT_W'(1));
    assign w_per_next = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;

    // Master carrier: held at 0 while disabled; the new period takes effect only at wrap.
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_cnt     <= '0;
            r_per_lat <= CNT_W'(MIN_PERIOD);
            r_sync    <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_sync <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_per_lat <= w_per_next;
            r_sync    <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_sync <= 1'b0;
        end
    end

    assign sync = r_sync;

    for (genvar k = 0; k < N_PHASES; k++) begin : g_phase
        logic [CNT_W+2:0] w_prod;
        logic [CNT_W-1:0] w_offset;
        logic [CNT_W:0]   w_sum;
        logic [CNT_W-1:0] w_cnt_k;

        // Offsets follow per_lat, so they change together with it at wrap.
        assign w_prod   = {3'b000, r_per_lat} * (CNT_W+3)'(k);
        assign w_offset = CNT_W'(w_prod >> LOG2N);
        // Both terms are below per_lat, so one conditional subtract is the modulo.
        assign w_sum    = {1'b0, r_cnt} + {1'b0, w_offset};
        assign w_cnt_k  = (w_sum >= {1'b0, r_per_lat}) ? CNT_W'(w_sum - {1'b0, r_per_lat})
                                                       : w_sum[CNT_W-1:0];

        pwm_phase_fsm #(
            .CNT_W (CNT_W),
            .DT_W  (DT_W),
            .I_W   (I_W)
        ) u_phase (
            .i_clk     (emu_clk),
            .i_rst     (emu_rst),
            .i_en      (en),
            .i_cnt_k   (w_cnt_k),
            .i_duty    (duty),
            .i_dt      (dt),
            .i_de_mode (de_mode),
            .i_ind     (i_ind[k*I_W +: I_W]),
            .i_th_hi   (th_hi),
            .i_th_lo   (th_lo),
            .o_hs      (hs[k]),
            .o_ls      (ls[k]),
            .o_ls_en   (ls_en[k])
        );
    end

endmodule

// File: tb/tb_multiphase_pwm_dte.sv
// Bench for multiphase_pwm_dte (2 phases): cycle reference model plus directed scenarios.
module tb_multiphase_pwm_dte;

    localparam int NP = 2;
    localparam int M_OFF = 0, M_HIGH = 1, M_GAP_HL = 2, M_LOW = 3, M_GAP_LH = 4;

    logic               clk = 1'b0;
    logic               rst, en, de_mode;
    logic [11:0]        period, duty;
    logic [5:0]         dt;
    logic [NP*16-1:0]   i_ind;
    logic signed [15:0] th_hi, th_lo;
    logic [NP-1:0]      hs, ls, ls_en;
    logic               sync;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    int m_cnt, m_per, m_sync;
    int m_duty [NP];
    bit m_lsen [NP];
    int m_mode [NP];
    int m_el   [NP];

    bit lh0[$], ll0[$], lh1[$], lsy[$];

    always #5 clk = ~clk;

    multiphase_pwm_dte #(.N_PHASES(NP), .CNT_W(12), .DT_W(6), .I_W(16)) dut (
        .emu_clk (clk),
        .emu_rst (rst),
        .en      (en),
        .period  (period),
        .duty    (duty),
        .dt      (dt),
        .de_mode (de_mode),
        .i_ind   (i_ind),
        .th_hi   (th_hi),
        .th_lo   (th_lo),
        .hs      (hs),
        .ls      (ls),
        .ls_en   (ls_en),
        .sync    (sync)
    );

    task automatic model_edge();
        int ck, dtv;
        bit dem, lsok;
        logic signed [15:0] iv;
        if (rst) begin
            m_cnt = 0; m_per = 2; m_sync = 0;
            for (int k = 0; k < NP; k++) begin
                m_duty[k] = 0; m_lsen[k] = 0; m_mode[k] = M_OFF; m_el[k] = 0;
            end
            return;
        end
        dtv = (dt == 0) ? 1 : int'(dt);
        for (int k = 0; k < NP; k++) begin
            ck   = (m_cnt + (m_per * k) / NP) % m_per;
            dem  = en && (ck < m_duty[k]);
            lsok = en && (!de_mode || m_lsen[k]);
            case (m_mode[k])
                M_OFF:    if (dem) m_mode[k] = M_HIGH;
                          else if (lsok) begin m_mode[k] = M_GAP_LH; m_el[k] = 1; end
                M_HIGH:   if (!dem) begin m_mode[k] = M_GAP_HL; m_el[k] = 1; end
                M_GAP_HL: if (dem) m_mode[k] = M_HIGH;
                          else if (m_el[k] >= dtv) m_mode[k] = lsok ? M_LOW : M_OFF;
                          else m_el[k]++;
                M_LOW:    if (dem || !lsok) begin m_mode[k] = M_GAP_LH; m_el[k] = 1; end
                default:  if (m_el[k] >= dtv) m_mode[k] = dem ? M_HIGH : (lsok ? M_LOW : M_OFF);
                          else m_el[k]++;
            endcase
            iv = i_ind[k*16 +: 16];
            if (iv > th_hi) m_lsen[k] = 1;
            else if (iv < th_lo) m_lsen[k] = 0;
            if (ck == 0) m_duty[k] = int'(duty);
        end
        if (!en) begin
            m_cnt = 0; m_sync = 0;
        end else if (m_cnt == m_per - 1) begin
            m_cnt = 0; m_sync = 1; m_per = (period < 2) ? 2 : int'(period);
        end else begin
            m_cnt++; m_sync = 0;
        end
    endtask

    // One clock: advance model, then compare DUT to model and the no-overlap rule.
    task automatic step();
        logic [NP-1:0] eh, el, ee;
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < NP; k++) begin
            eh[k] = (m_mode[k] == M_HIGH);
            el[k] = (m_mode[k] == M_LOW);
            ee[k] = m_lsen[k];
        end
        checks++;
        if ({hs, ls, ls_en, sync} !== {eh, el, ee, m_sync[0]}) begin
            errors++;
            $display("FAIL model cyc=%0d got hs=%b ls=%b ls_en=%b sync=%b exp hs=%b ls=%b ls_en=%b sync=%b",
                     cyc, hs, ls, ls_en, sync, eh, el, ee, m_sync[0]);
        end
        checks++;
        if ((hs & ls) !== '0) begin
            errors++;
            $display("FAIL overlap cyc=%0d got hs&ls=%b exp 0", cyc, hs & ls);
        end
        lh0.push_back(hs[0]); ll0.push_back(ls[0]); lh1.push_back(hs[1]); lsy.push_back(sync);
        cyc++;
    endtask

    task automatic clear_logs();
        lh0.delete(); ll0.delete(); lh1.delete(); lsy.delete();
    endtask

    function automatic int find_edge(input bit q[$], input int from, input bit val);
        for (int i = (from < 1) ? 1 : from; i < q.size(); i++)
            if (q[i] == val && q[i-1] != val) return i;
        return -1;
    endfunction

    task automatic wait_gate(input bit sel_ls, input bit val, input int limit);
        int n = 0;
        while (((sel_ls ? ls[0] : hs[0]) !== val) && n < limit) begin step(); n++; end
        checks++;
        if ((sel_ls ? ls[0] : hs[0]) !== val) begin
            errors++;
            $display("FAIL wait_gate sel_ls=%0d got timeout after %0d cycles, need value %0d", sel_ls, n, val);
        end
    endtask

    task automatic set_nominal(input int per, input int dty, input int dtc);
        period = 12'(per); duty = 12'(dty); dt = 6'(dtc);
        de_mode = 0; th_hi = 16'sd10; th_lo = 16'sd5; i_ind = {16'sd1000, 16'sd1000}; en = 1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; de_mode = 0; period = 100; duty = 50; dt = 3;
        th_hi = 16'sd10; th_lo = 16'sd5; i_ind = {16'sd1000, 16'sd1000};
        repeat (3) step();
        checks++;
        if ({hs, ls, ls_en, sync} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {hs, ls, ls_en, sync});
        end
        rst = 0;
        repeat (5) step();
    endtask

    task automatic test_steady();
        int r0, f0, lr, lf, r1, s1, s2;
        set_nominal(100, 50, 3);
        clear_logs();
        repeat (500) step();
        r0 = find_edge(lh0, 250, 1); f0 = find_edge(lh0, r0, 0);
        lr = find_edge(ll0, f0, 1);  lf = find_edge(ll0, lr, 0);
        r1 = find_edge(lh1, r0, 1);
        s1 = find_edge(lsy, 250, 1); s2 = find_edge(lsy, s1 + 1, 1);
        checks++; if (f0 - r0 !== 47) begin errors++; $display("FAIL hs_width got %0d exp 47", f0 - r0); end
        checks++; if (lr - f0 !== 3)  begin errors++; $display("FAIL hl_gap got %0d exp 3", lr - f0); end
        checks++; if (lf - lr !== 47) begin errors++; $display("FAIL ls_width got %0d exp 47", lf - lr); end
        checks++; if (r1 - r0 !== 50) begin errors++; $display("FAIL phase1_delay got %0d exp 50", r1 - r0); end
        checks++; if (s2 - s1 !== 100 || s1 < 0) begin errors++; $display("FAIL sync_interval got %0d exp 100", s2 - s1); end
    endtask

    task automatic test_diode_emulation();
        int en_fall = -1, ls_fall = -1, bad = 0;
        set_nominal(100, 50, 3);
        de_mode = 1; i_ind = {16'sd20, 16'sd20};
        wait_gate(1, 0, 300);
        wait_gate(1, 1, 300);
        for (int v = 20; v >= 0; v--) begin
            i_ind[15:0] = 16'(v);
            step();
            if (en_fall < 0 && ls_en[0] === 1'b0) en_fall = cyc;
            if (ls_fall < 0 && ls[0] === 1'b0) ls_fall = cyc;
        end
        checks++;
        if (ls_fall - en_fall !== 1 || en_fall < 0) begin
            errors++; $display("FAIL de_ls_drop got lag %0d exp 1", ls_fall - en_fall);
        end
        i_ind[15:0] = 16'sd10;
        repeat (150) begin step(); if (ls_en[0] !== 1'b0 || ls[0] !== 1'b0) bad++; end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL de_no_reenable got %0d active cycles exp 0", bad); end
        i_ind[15:0] = 16'sd11;
        step();
        checks++;
        if (ls_en[0] !== 1'b1) begin errors++; $display("FAIL de_reenable got %b exp 1", ls_en[0]); end
    endtask

    task automatic test_duty_extremes();
        int hi_cnt = 0, lo_cnt = 0, ls_cnt = 0;
        set_nominal(100, 0, 3);
        for (int i = 0; i < 300; i++) begin step(); if (i >= 150 && hs !== 2'b00) hi_cnt++; end
        checks++;
        if (hi_cnt !== 0) begin errors++; $display("FAIL duty0 got %0d hs cycles exp 0", hi_cnt); end
        duty = 100;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i >= 150 && hs !== 2'b11) lo_cnt++;
            if (i >= 150 && ls !== 2'b00) ls_cnt++;
        end
        checks++;
        if (lo_cnt !== 0) begin errors++; $display("FAIL duty100_hs got %0d low cycles exp 0", lo_cnt); end
        checks++;
        if (ls_cnt !== 0) begin errors++; $display("FAIL duty100_ls got %0d ls cycles exp 0", ls_cnt); end
    endtask

    task automatic test_dt_zero();
        int f, r, lf, hr;
        set_nominal(20, 10, 0);
        clear_logs();
        repeat (120) step();
        f = find_edge(lh0, 60, 0); r = find_edge(ll0, f, 1);
        lf = find_edge(ll0, r, 0); hr = find_edge(lh0, lf, 1);
        checks++; if (r - f !== 1 || f < 0)   begin errors++; $display("FAIL dt0_hl_gap got %0d exp 1", r - f); end
        checks++; if (hr - lf !== 1 || lf < 0) begin errors++; $display("FAIL dt0_lh_gap got %0d exp 1", hr - lf); end
    endtask

    task automatic test_en_drop();
        int active = 0, n = 0;
        set_nominal(100, 50, 4);
        repeat (250) step();
        wait_gate(0, 1, 200);
        en = 0;
        repeat (30) begin step(); if ({hs, ls, sync} !== '0) active++; end
        checks++;
        if (active !== 0) begin errors++; $display("FAIL en_drop_outputs got %0d active cycles exp 0", active); end
        en = 1;
        do begin step(); n++; end while (sync !== 1'b1 && n < 300);
        checks++;
        if (n !== 100) begin errors++; $display("FAIL en_drop_cnt_held got first sync at %0d exp 100", n); end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        set_nominal(100, 50, 3);
        wait_gate(1, 0, 300);
        wait_gate(1, 1, 300);
        rst = 1;
        step();
        checks++;
        if ({hs, ls, ls_en, sync} !== '0) begin
            errors++; $display("FAIL mid_reset got %b exp 0", {hs, ls, ls_en, sync});
        end
        rst = 0;
        do begin step(); n++; end while (sync !== 1'b1 && n < 20);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL reset_per_lat got first sync at %0d exp 2", n); end
    endtask

    task automatic test_random();
        int th;
        for (int c = 0; c < 10000; c++) begin
            if (c % 64 == 0) begin
                period  = 12'($urandom_range(0, 60));
                duty    = 12'($urandom_range(0, 70));
                de_mode = 1'($urandom_range(0, 1));
                th      = int'($urandom_range(0, 20));
                th_hi   = 16'(th);
                th_lo   = 16'(th - int'($urandom_range(0, 20)));
                en      = ($urandom_range(0, 9) != 0);
            end
            if (c % 16 == 0) dt = 6'($urandom_range(0, 6));
            rst = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < NP; k++) i_ind[k*16 +: 16] = 16'(int'($urandom_range(0, 80)) - 40);
            step();
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_diode_emulation();
        test_duty_extremes();
        test_dt_zero();
        test_en_drop();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiphase_pwm_dte.md
Name: multiphase_pwm_dte

Overview:
- Parametrised successor to the single-phase fixed-duty PWM with comparator-gated low side used in the buck emulation benches.
- Generates N interleaved hs/ls gate pairs with runtime period and duty, programmable dead time, and per-phase diode emulation (hysteretic inductor-current comparator).
- Sits between the digital controller and the msdsl buck power-stage models, clocked on the emulator clock.

Parameters:
- N_PHASES, 2, number of interleaved phases; power of two, 1..8.
- CNT_W, 12, carrier counter, period and duty width (unsigned).
- DT_W, 6, dead-time count width (unsigned).
- I_W, 16, fixed-point width of inductor-current samples and thresholds (signed).

Ports:
- emu_clk  in  1  emulator clock.
- emu_rst  in  1  reset, synchronous, active-high.
- en  in  1  converter enable.
- period  in  CNT_W  carrier period in cycles; latched at wrap.
- duty  in  CNT_W  high-side on-count; latched per phase at phase start.
- dt  in  DT_W  dead time in cycles.
- de_mode  in  1  1 = diode emulation active; 0 = forced synchronous rectification.
- i_ind  in  N_PHASES*I_W  per-phase inductor current, signed, phase k at [k*I_W +: I_W].
- th_hi  in  I_W  signed set threshold for ls enable.
- th_lo  in  I_W  signed clear threshold; th_lo <= th_hi is required of the driver.
- hs  out  N_PHASES  high-side gate.
- ls  out  N_PHASES  low-side gate.
- ls_en  out  N_PHASES  comparator state, for probing.
- sync  out  1  one-cycle pulse when the master counter wraps to 0.

Behaviour:
- Reset: cnt=0, per_lat=2, all duty_lat=0, all FSMs in IDLE, hs=ls=ls_en=0, sync=0.
- Master counter:
  - en=1: cnt increments each cycle; at cnt==per_lat-1 wraps to 0, sync=1 that cycle, per_lat <= max(period,2).
  - en=0: cnt held at 0 and sync=0.
- Phase counter: offset_k = (per_lat*k)>>log2(N_PHASES), recomputed at wrap; cnt_k = (cnt+offset_k) mod per_lat.
- Duty latch: duty_lat_k <= duty when cnt_k==0.
- Demand: dem_k = en & (cnt_k < duty_lat_k).
  - duty=0 gives 0 %.
  - duty >= per_lat gives 100 %; hs stays high with no dead time.
- Comparator: ls_en_k set when i_ind_k > th_hi; cleared when i_ind_k < th_lo; otherwise holds. Registered, 1 cycle latency.
- Low side allowed: ls_ok_k = en & (~de_mode | ls_en_k).
- Per-phase FSM states: IDLE, HS, DT_HL, LS, DT_LH. Outputs are registered decodes: hs=(state==HS), ls=(state==LS).
- Transitions:
  - IDLE: dem → HS; else if ls_ok → DT_LH with dt_cnt=0 (guard before LS).
  - HS: !dem → DT_HL.
  - DT_HL: dem → HS; else when dt_cnt reaches max(dt,1)-1 → LS if ls_ok, else IDLE.
  - LS: dem or !ls_ok → DT_LH.
  - DT_LH: when dt_cnt reaches max(dt,1)-1 → HS if dem, else LS if ls_ok, else IDLE.
- Dead-time states last exactly max(dt,1) cycles; dt_cnt resets on every entry.
- Latency: dem change → gate change is 1 cycle.
- Invariants:
  - hs_k & ls_k never both 1.
  - Any hs/ls swap passes through ≥1 dead-time cycle.
- en falling: HS and LS drain through their dead-time state to IDLE; no new HS.
- Mid-run reset: next cycle all outputs 0; no dead-time drain.
- dt changed mid dead time: the new value applies from the next cycle's compare.

Decomposition:
- Package buck_ctrl_pkg: phase_state_t enum, MIN_PERIOD=2, MIN_DT=1 constants.
- Sub-module pwm_phase_fsm (one per phase, generate loop): duty latch, comparator, dead-time counter, FSM.
- The top owns the master counter, period latch and offsets.

Test Plan:
- N=2, period=100, duty=50, dt=3, de_mode=0, i_ind=+1000 → each hs high 47 cycles, ls high 47 cycles, 3-cycle gaps; phase 1 delayed 50 cycles; sync every 100 cycles.
- de_mode=1, th_hi=10, th_lo=5, i_ind ramp 20→0 during LS → ls drops one cycle after i<5 and enters DT_LH; no re-enable until i>10.
- duty=0 then duty=100 (period 100) → hs never high, then hs continuously high; change applied only at cnt_k==0.
- dt=0 → dead time is exactly 1 cycle; assertion that hs&ls is never both 1 holds over 10k random cycles with random duty/dt/i_ind.
- en dropped while in HS with dt=4 → 4-cycle DT_HL, then IDLE; outputs stay 0 and cnt stays 0.
- emu_rst asserted while in LS → ls=0 next cycle; all state as reset.
